// File: rtl/picosoc_timer_pkg.sv
// Shared register map, control/status bit positions and the byte-strobe merge
// helper used by the PicoSoC down-counting timer.
package picosoc_timer_pkg;

  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_LOAD   = 8'h04;
  localparam logic [7:0] TMR_COUNT  = 8'h08;
  localparam logic [7:0] TMR_STATUS = 8'h0C;
  localparam logic [7:0] TMR_PRESC  = 8'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_RELOAD    = 1;
  localparam int CTRL_IRQEN     = 2;
  localparam int STATUS_EXPIRED = 0;

  // Replace only the bytes whose write strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/picosoc_timer_presc.sv
// Prescaler: counts 0..presc while enabled and flags a tick on the terminal
// count; clr restarts the count from 0.
module picosoc_timer_presc #(
  parameter int PRESC_BITS = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESC_BITS-1:0] presc,
  output logic                  tick
);

  logic [PRESC_BITS-1:0] cnt_reg;

  assign tick = en && (cnt_reg == presc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (clr || !en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/picosoc_timer.sv
// Memory-mapped down-counting timer on the PicoSoC iomem bus with prescaler,
// one-shot/auto-reload modes and a sticky expiry flag driving a level irq.
module picosoc_timer
  import picosoc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESC_BITS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic [7:0]            offset;
  logic                  in_window, accept, wr_en;
  logic                  ctrl_wr, load_wr, count_wr, status_wr, presc_wr;
  logic                  tick, expire;
  logic                  en_reg, reload_reg, irq_en_reg, expired_reg, ready_reg;
  logic [31:0]           load_reg, count_reg, rdata_reg, rd_data;
  logic [PRESC_BITS-1:0] presc_reg, presc_next;

  assign offset    = iomem_addr[7:0];
  assign in_window = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign accept    = iomem_valid && in_window && !ready_reg;
  assign wr_en     = accept && (iomem_wstrb != 4'b0000);

  assign ctrl_wr   = wr_en && (offset == TMR_CTRL) && iomem_wstrb[0];
  assign load_wr   = wr_en && (offset == TMR_LOAD);
  assign count_wr  = wr_en && (offset == TMR_COUNT);
  assign status_wr = wr_en && (offset == TMR_STATUS) && iomem_wstrb[0];
  assign presc_wr  = wr_en && (offset == TMR_PRESC);

  // A COUNT write on a tick cycle suppresses both decrement and expiry.
  assign expire = tick && !count_wr && (count_reg == 32'd0);

  for (genvar gi = 0; gi < PRESC_BITS; gi++) begin : g_presc_bit
    assign presc_next[gi] = iomem_wstrb[gi/8] ? iomem_wdata[gi] : presc_reg[gi];
  end

  picosoc_timer_presc #(
    .PRESC_BITS(PRESC_BITS)
  ) u_presc (
    .clk   (clk),
    .resetn(resetn),
    .en    (en_reg),
    .clr   (presc_wr),
    .presc (presc_reg),
    .tick  (tick)
  );

  always_comb begin
    rd_data = '0;
    case (offset)
      TMR_CTRL: begin
        rd_data[CTRL_EN]     = en_reg;
        rd_data[CTRL_RELOAD] = reload_reg;
        rd_data[CTRL_IRQEN]  = irq_en_reg;
      end
      TMR_LOAD:   rd_data = load_reg;
      TMR_COUNT:  rd_data = count_reg;
      TMR_STATUS: rd_data[STATUS_EXPIRED] = expired_reg;
      TMR_PRESC:  rd_data[PRESC_BITS-1:0] = presc_reg;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_reg   <= 1'b0;
      rdata_reg   <= '0;
      en_reg      <= 1'b0;
      reload_reg  <= 1'b0;
      irq_en_reg  <= 1'b0;
      expired_reg <= 1'b0;
      load_reg    <= '0;
      count_reg   <= '0;
      presc_reg   <= '0;
    end else begin
      ready_reg <= accept;
      rdata_reg <= (accept && (iomem_wstrb == 4'b0000)) ? rd_data : 32'd0;

      if (load_wr) load_reg <= apply_wstrb(load_reg, iomem_wdata, iomem_wstrb);

      if (count_wr) begin
        count_reg <= apply_wstrb(count_reg, iomem_wdata, iomem_wstrb);
      end else if (tick) begin
        if (count_reg != 32'd0) count_reg <= count_reg - 32'd1;
        else if (reload_reg)    count_reg <= load_reg;
      end

      if (ctrl_wr) begin
        en_reg     <= iomem_wdata[CTRL_EN];
        reload_reg <= iomem_wdata[CTRL_RELOAD];
        irq_en_reg <= iomem_wdata[CTRL_IRQEN];
      end else if (expire && !reload_reg) begin
        en_reg <= 1'b0;
      end

      if (expire) expired_reg <= 1'b1;
      else if (status_wr && iomem_wdata[STATUS_EXPIRED]) expired_reg <= 1'b0;

      if (presc_wr) presc_reg <= presc_next;
    end
  end

  assign iomem_ready = ready_reg;
  assign iomem_rdata = rdata_reg;
  assign irq         = expired_reg && irq_en_reg;

endmodule
